// File: rtl/uart_transceiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_transceiver                                              |
// | Purpose  : Full-duplex UART. The TX path serialises one word per frame   |
// |            using a BIT_CYCLES-cycle bit timer. The RX path synchronises  |
// |            rxd, oversamples it, and presents words through a valid/ready |
// |            holding register with parity, framing and overrun flags.     |
// | Ports    : clk, rst (sync, active-high)                                  |
// |            rxd / txd            serial line in / out, idle high          |
// |            tx_data/tx_valid/tx_ready   word to send, handshake           |
// |            rx_data/rx_valid/rx_ready   received word, handshake          |
// |            rx_parity_err, rx_frame_err flags for the held word           |
// |            rx_overrun                  sticky: a frame was dropped       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_transceiver #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int BIT_CYCLES = CLOCK_RATE / BAUD_RATE;
  localparam int TICK_DIV   = BIT_CYCLES / OVERSAMPLE;
  localparam int CW         = $clog2(BIT_CYCLES + 1);
  localparam int DW         = $clog2(TICK_DIV + 1);
  localparam int TW         = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          PAR_EN    = (PARITY != 0);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  // ---------------------------------------------------------------- TX path
  state_t                tx_state;
  logic [CW-1:0]         tx_cnt;
  logic [3:0]            tx_bit;
  logic                  tx_stop;
  logic [DATA_BITS-1:0]  tx_shift;
  logic                  tx_par;
  logic                  tx_bit_end;

  assign tx_bit_end = (tx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      if (tx_state != ST_IDLE)
        tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            // Word and its parity are captured here so tx_data may change freely.
            tx_shift <= tx_data;
            tx_par   <= (^tx_data) ^ PAR_ODD;
            tx_cnt   <= '0;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_bit_end) begin
            tx_bit   <= '0;
            txd      <= tx_shift[0];
            tx_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit == DATA_LAST) begin
              tx_stop  <= 1'b0;
              txd      <= PAR_EN ? tx_par : 1'b1;
              tx_state <= PAR_EN ? ST_PAR : ST_STOP;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= tx_shift >> 1;
              txd      <= tx_shift[1];
            end
          end
        end
        ST_PAR: begin
          if (tx_bit_end) begin
            txd      <= 1'b1;
            tx_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tx_bit_end) begin
            if (tx_stop == STOP_LAST) begin
              tx_ready <= 1'b1;
              tx_state <= ST_IDLE;
            end else begin
              tx_stop <= 1'b1;
            end
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  state_t                rx_state;
  logic                  rx_meta, rx_sync, rx_prev;
  logic [DW-1:0]         rx_div;
  logic [TW-1:0]         rx_tick;
  logic [3:0]            rx_bit;
  logic [DATA_BITS-1:0]  rx_shift;
  logic                  rx_par;
  logic                  tick;

  assign tick = (rx_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state      <= ST_IDLE;
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      rx_div        <= '0;
      rx_tick       <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_par        <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      if (rx_state != ST_IDLE)
        rx_div <= tick ? '0 : rx_div + 1'b1;
      case (rx_state)
        ST_IDLE: begin
          // Requires a seen-high line before the low: a held break cannot re-arm.
          if (rx_prev && !rx_sync) begin
            rx_div   <= '0;
            rx_tick  <= '0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_tick == HALF_LAST) begin
              // Later samples land one full bit after this mid-bit point.
              rx_tick  <= '0;
              rx_bit   <= '0;
              rx_state <= rx_sync ? ST_IDLE : ST_DATA;
            end else begin
              rx_tick <= rx_tick + 1'b1;
            end
          end
        end
        ST_DATA, ST_PAR, ST_STOP: begin
          if (tick) begin
            if (rx_tick == OS_LAST) begin
              rx_tick <= '0;
              if (rx_state == ST_DATA) begin
                rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                rx_bit   <= rx_bit + 1'b1;
                if (rx_bit == DATA_LAST)
                  rx_state <= PAR_EN ? ST_PAR : ST_STOP;
              end else if (rx_state == ST_PAR) begin
                rx_par   <= rx_sync;
                rx_state <= ST_STOP;
              end else begin
                rx_state <= ST_IDLE;
                // A handshake on this same edge frees the holding register.
                if (!rx_valid || rx_ready) begin
                  rx_data       <= rx_shift;
                  rx_valid      <= 1'b1;
                  rx_frame_err  <= ~rx_sync;
                  rx_parity_err <= PAR_EN & (rx_par ^ (^rx_shift) ^ PAR_ODD);
                end else begin
                  rx_overrun <= 1'b1;
                end
              end
            end else begin
              rx_tick <= rx_tick + 1'b1;
            end
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_transceiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_transceiver                                           |
// | Purpose  : Directed + random bench for uart_transceiver. Three instances: |
// |            u0 8N1 (loopback or bench-driven rx), u1 8E1 (bench-driven    |
// |            rx), u2 9-bit odd parity 2 stop (loopback). Expected frames   |
// |            come from a bit-list model of the line format.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_transceiver;

  localparam int NB  [3] = '{8, 8, 9};
  localparam int PAR [3] = '{0, 2, 1};
  localparam int STP [3] = '{1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [8:0] tx_din [3];
  logic       txv [3], rxr [3], loop [3], drv [3];
  logic       txl [3], txr [3], rxv [3], pe [3], fe [3], ov [3];
  logic [8:0] rxdat [3];

  logic       txd_0, txr_0, rxv_0, pe_0, fe_0, ov_0, rxl_0;
  logic       txd_1, txr_1, rxv_1, pe_1, fe_1, ov_1, rxl_1;
  logic       txd_2, txr_2, rxv_2, pe_2, fe_2, ov_2, rxl_2;
  logic [7:0] rxdat_0, rxdat_1;
  logic [8:0] rxdat_2;

  assign rxl_0 = loop[0] ? txd_0 : drv[0];
  assign rxl_1 = loop[1] ? txd_1 : drv[1];
  assign rxl_2 = loop[2] ? txd_2 : drv[2];

  always_comb begin
    txl[0] = txd_0;  txl[1] = txd_1;  txl[2] = txd_2;
    txr[0] = txr_0;  txr[1] = txr_1;  txr[2] = txr_2;
    rxv[0] = rxv_0;  rxv[1] = rxv_1;  rxv[2] = rxv_2;
    pe[0]  = pe_0;   pe[1]  = pe_1;   pe[2]  = pe_2;
    fe[0]  = fe_0;   fe[1]  = fe_1;   fe[2]  = fe_2;
    ov[0]  = ov_0;   ov[1]  = ov_1;   ov[2]  = ov_2;
    rxdat[0] = {1'b0, rxdat_0};
    rxdat[1] = {1'b0, rxdat_1};
    rxdat[2] = rxdat_2;
  end

  uart_transceiver #(.CLOCK_RATE(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                     .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u0 (
    .clk(clk), .rst(rst), .rxd(rxl_0), .txd(txd_0),
    .tx_data(tx_din[0][7:0]), .tx_valid(txv[0]), .tx_ready(txr_0),
    .rx_data(rxdat_0), .rx_valid(rxv_0), .rx_ready(rxr[0]),
    .rx_parity_err(pe_0), .rx_frame_err(fe_0), .rx_overrun(ov_0));

  uart_transceiver #(.CLOCK_RATE(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                     .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) u1 (
    .clk(clk), .rst(rst), .rxd(rxl_1), .txd(txd_1),
    .tx_data(tx_din[1][7:0]), .tx_valid(txv[1]), .tx_ready(txr_1),
    .rx_data(rxdat_1), .rx_valid(rxv_1), .rx_ready(rxr[1]),
    .rx_parity_err(pe_1), .rx_frame_err(fe_1), .rx_overrun(ov_1));

  uart_transceiver #(.CLOCK_RATE(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(9),
                     .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(16)) u2 (
    .clk(clk), .rst(rst), .rxd(rxl_2), .txd(txd_2),
    .tx_data(tx_din[2]), .tx_valid(txv[2]), .tx_ready(txr_2),
    .rx_data(rxdat_2), .rx_valid(rxv_2), .rx_ready(rxr[2]),
    .rx_parity_err(pe_2), .rx_frame_err(fe_2), .rx_overrun(ov_2));

  int total = 0;
  int bad   = 0;

  // Received words {parity_err, frame_err, data} captured at each handshake.
  logic [10:0] gq0 [$];
  logic [10:0] gq1 [$];
  logic [10:0] gq2 [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (rxv[0] && rxr[0]) gq0.push_back({pe[0], fe[0], rxdat[0]});
      if (rxv[1] && rxr[1]) gq1.push_back({pe[1], fe[1], rxdat[1]});
      if (rxv[2] && rxr[2]) gq2.push_back({pe[2], fe[2], rxdat[2]});
    end
  end

  function automatic int qsize(input int w);
    case (w)
      0:       return gq0.size();
      1:       return gq1.size();
      default: return gq2.size();
    endcase
  endfunction

  function automatic logic [10:0] qpop(input int w);
    case (w)
      0:       return gq0.pop_front();
      1:       return gq1.pop_front();
      default: return gq2.pop_front();
    endcase
  endfunction

  // Line image of a frame: index 0 is the start bit, then LSB-first data,
  // optional parity chosen so the total count of ones is even/odd, then stops.
  function automatic logic [15:0] frame_vec(input int data, input int nb, input int par,
                                            input int stops, output int len);
    logic [15:0] v;
    int ones;
    int n;
    v = '1;
    ones = 0;
    v[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nb; i++) begin
      v[n] = (((data >> i) & 1) == 1);
      ones += (data >> i) & 1;
      n++;
    end
    if (par == 2) begin
      v[n] = ((ones % 2) == 1);
      n++;
    end else if (par == 1) begin
      v[n] = ((ones % 2) == 0);
      n++;
    end
    len = n + stops;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_line(input int w, input logic [15:0] v, input int len);
    for (int i = 0; i < len; i++) begin
      drv[w] = v[i];
      cyc(16);
    end
    drv[w] = 1'b1;
  endtask

  task automatic expect_rx(input int w, input logic [10:0] exp, input string tag);
    int k;
    k = 0;
    while (qsize(w) == 0 && k < 400) begin
      cyc(1);
      k++;
    end
    chk({tag, "_arrived"}, 32'(qsize(w) != 0), 1);
    if (qsize(w) != 0) chk(tag, qpop(w), exp);
  endtask

  // Sends one word and checks every cycle of the line against the model.
  task automatic tx_frame(input int w, input int data, input string tag);
    logic [15:0] v;
    int len, hit, low, k;
    v = frame_vec(data, NB[w], PAR[w], STP[w], len);
    k = 0;
    while (txr[w] !== 1'b1 && k < 2000) begin
      cyc(1);
      k++;
    end
    chk({tag, "_rdy"}, txr[w], 1);
    tx_din[w] = 9'(data);
    txv[w] = 1'b1;
    cyc(1);
    txv[w] = 1'b0;
    tx_din[w] = ~tx_din[w];
    low = 0;
    for (int i = 0; i < len; i++) begin
      hit = 0;
      for (int c = 0; c < 16; c++) begin
        if (txl[w] === v[i]) hit++;
        if (txr[w] === 1'b0) low++;
        cyc(1);
      end
      chk($sformatf("%s_b%0d", tag, i), hit, 16);
    end
    chk({tag, "_busy_cycles"}, low, 16 * len);
    chk({tag, "_idle_rdy"}, txr[w], 1);
    chk({tag, "_idle_txd"}, txl[w], 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  int          d, flen, seen;
  logic [15:0] fv;

  initial begin
    for (int w = 0; w < 3; w++) begin
      tx_din[w] = '0;
      txv[w]    = 1'b0;
      rxr[w]    = 1'b1;
      drv[w]    = 1'b1;
    end
    loop[0] = 1'b1;
    loop[1] = 1'b0;
    loop[2] = 1'b1;

    // Reset values, with a word offered during reset.
    rst = 1'b1;
    txv[0] = 1'b1;
    tx_din[0] = 9'h0F0;
    cyc(3);
    chk("rst_txd", txl[0], 1);
    chk("rst_tx_ready", txr[0], 1);
    chk("rst_rx_valid", rxv[0], 0);
    chk("rst_rx_data", rxdat[0], 0);
    chk("rst_perr", pe[0], 0);
    chk("rst_ferr", fe[0], 0);
    chk("rst_ovr", ov[0], 0);
    txv[0] = 1'b0;
    rst = 1'b0;
    cyc(2);
    chk("no_accept_in_rst", txl[0], 1);

    // 8N1 loopback of 0xA5, then random words.
    tx_frame(0, 'hA5, "a5");
    expect_rx(0, 11'h0A5, "a5_rx");
    for (int i = 0; i < 4; i++) begin
      d = int'($urandom_range(0, 255));
      tx_frame(0, d, "lb");
      expect_rx(0, 11'(d), "lb_rx");
    end

    // 8E1: random good frames, a forced bad parity bit, and one TX frame.
    for (int i = 0; i < 3; i++) begin
      d = int'($urandom_range(0, 255));
      fv = frame_vec(d, 8, 2, 1, flen);
      drive_line(1, fv, flen);
      expect_rx(1, 11'(d), "e_rx");
    end
    fv = frame_vec('h03, 8, 2, 1, flen);
    fv[9] = 1'b1;
    drive_line(1, fv, flen);
    expect_rx(1, {2'b10, 9'h003}, "e_bad_parity");
    tx_frame(1, int'($urandom_range(0, 255)), "e_tx");

    // Overrun: two frames with rx_ready low.
    loop[0] = 1'b0;
    rxr[0] = 1'b0;
    drive_line(0, frame_vec('h11, 8, 0, 1, flen), 10);
    drive_line(0, frame_vec('h22, 8, 0, 1, flen), 10);
    cyc(4);
    chk("ovr_valid", rxv[0], 1);
    chk("ovr_data", rxdat[0], 'h11);
    chk("ovr_flag", ov[0], 1);
    rxr[0] = 1'b1;
    cyc(1);
    chk("ovr_hs_valid", rxv[0], 0);
    chk("ovr_sticky", ov[0], 1);
    expect_rx(0, 11'h011, "ovr_word");

    // Short low glitch on an idle line, then a normal frame.
    drv[0] = 1'b0;
    cyc(4);
    drv[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (rxv[0] === 1'b1) seen++;
      cyc(1);
    end
    chk("glitch_valid_cycles", seen, 0);
    chk("glitch_queue", qsize(0), 0);
    d = int'($urandom_range(0, 255));
    drive_line(0, frame_vec(d, 8, 0, 1, flen), flen);
    expect_rx(0, 11'(d), "post_glitch");

    // Break: one all-zero word with frame error, no re-arm while low.
    drv[0] = 1'b0;
    cyc(300);
    drv[0] = 1'b1;
    cyc(60);
    chk("break_count", qsize(0), 1);
    expect_rx(0, {2'b01, 9'h000}, "break_word");

    // Reset during TX data bit 3 of 0x00, then a clean 0x5A.
    tx_din[0] = 9'h000;
    txv[0] = 1'b1;
    cyc(1);
    txv[0] = 1'b0;
    cyc(16 + 48 + 8);
    chk("abort_inflight_txd", txl[0], 0);
    rst = 1'b1;
    cyc(1);
    chk("abort_txd", txl[0], 1);
    chk("abort_rdy", txr[0], 1);
    chk("abort_ovr_cleared", ov[0], 0);
    rst = 1'b0;
    cyc(1);
    loop[0] = 1'b1;
    tx_frame(0, 'h5A, "post_abort");
    expect_rx(0, 11'h05A, "post_abort_rx");

    // 9 data bits, odd parity, 2 stop bits, back to back.
    tx_frame(2, 'h1FF, "n9a");
    tx_frame(2, 'h1FF, "n9b");
    expect_rx(2, 11'h1FF, "n9a_rx");
    expect_rx(2, 11'h1FF, "n9b_rx");
    for (int i = 0; i < 2; i++) begin
      d = int'($urandom_range(0, 511));
      tx_frame(2, d, "n9r");
      expect_rx(2, 11'(d), "n9r_rx");
    end

    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
